// File: rtl/reflect_sensors.sv
`default_nettype none
// ============================================================================
//  Module   : reflect_sensors
//  Purpose  : Models the pod's three optical reflective-stripe sensors
//             (front, middle, rear). Each sensor location is the pod
//             reference position plus a fixed offset. A sensor output is
//             high while that location lies over one of NUM_STRIPES
//             regularly spaced stripes. The leading edge of a stripe counts
//             as over it; the trailing edge does not.
//  Ports    : clk          - system clock, rising edge
//             rst_n        - asynchronous active-low reset
//             position     - pod reference position along the tube (nm, unsigned)
//             reflectF/M/R - front/middle/rear sensor over a stripe (registered)
//             stripeCount  - saturating count of reflectF rising edges
//                            (only when REFLECT_STRIPE_COUNT_EN is defined)
//  Options  : `define REFLECT_STRIPE_COUNT_EN to add the stripeCount output
//  Latency  : position sampled at edge n appears on the outputs after edge n+1
//  Revision : 1.0 - initial release
// ============================================================================
module reflect_sensors #(
   parameter logic [63:0] FIRST_STRIPE = 64'd30480000000,
   parameter logic [63:0] STRIPE_PITCH = 64'd30480000000,
   parameter logic [63:0] STRIPE_WIDTH = 64'd101600000,
   parameter int          NUM_STRIPES  = 41,
   parameter logic [63:0] OFFSET_F     = 64'd2540000000,
   parameter logic [63:0] OFFSET_M     = 64'd1270000000,
   parameter logic [63:0] OFFSET_R     = 64'd0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [63:0] position,
   output logic        reflectF,
   output logic        reflectM,
   output logic        reflectR
`ifdef REFLECT_STRIPE_COUNT_EN
   ,
   output logic [7:0]  stripeCount
`endif
);

   // Compare the location against every stripe window. All window bounds
   // are constants, so this becomes a bank of constant comparators and
   // avoids a 64-bit divider. The 72-bit arithmetic keeps windows that
   // would lie beyond 2^64 from wrapping back into range.
   function automatic logic stripe_hit(input logic [64:0] loc);
      logic [71:0] lo;
      logic [71:0] hi;
      logic [71:0] loc_w;
      stripe_hit = 1'b0;
      loc_w      = {7'd0, loc};
      // Bit 64 set means position + offset overflowed: never a hit.
      if (!loc[64]) begin
         for (int k = 0; k < NUM_STRIPES; k++) begin
            lo = 72'(FIRST_STRIPE) + 72'(k) * 72'(STRIPE_PITCH);
            hi = lo + 72'(STRIPE_WIDTH);
            if ((loc_w >= lo) && (loc_w < hi)) begin
               stripe_hit = 1'b1;
            end
         end
      end
   endfunction

   // Input capture stage. It is deliberately not reset: it keeps tracking
   // position while rst_n is low. The first edge after release then
   // presents a valid evaluation.
   logic [63:0] r_pos;

   always_ff @(posedge clk) begin
      r_pos <= position;
   end

   logic [64:0] w_loc_f;
   logic [64:0] w_loc_m;
   logic [64:0] w_loc_r;
   logic        w_hit_f;
   logic        w_hit_m;
   logic        w_hit_r;

   assign w_loc_f = {1'b0, r_pos} + {1'b0, OFFSET_F};
   assign w_loc_m = {1'b0, r_pos} + {1'b0, OFFSET_M};
   assign w_loc_r = {1'b0, r_pos} + {1'b0, OFFSET_R};

   assign w_hit_f = stripe_hit(w_loc_f);
   assign w_hit_m = stripe_hit(w_loc_m);
   assign w_hit_r = stripe_hit(w_loc_r);

   // Registered outputs keep the outputs glitch-free.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reflectF <= 1'b0;
         reflectM <= 1'b0;
         reflectR <= 1'b0;
      end else begin
         reflectF <= w_hit_f;
         reflectM <= w_hit_m;
         reflectR <= w_hit_r;
      end
   end

`ifdef REFLECT_STRIPE_COUNT_EN
   // The count updates on the same edge that raises reflectF, so the new
   // value is visible in the same cycle as the rising output.
   logic [7:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= 8'd0;
      end else if (w_hit_f && !reflectF && (r_count != 8'hFF)) begin
         r_count <= r_count + 8'd1;
      end
   end

   assign stripeCount = r_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reflect_sensors.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reflect_sensors
//  Purpose  : Directed self-checking bench for reflect_sensors. Expected
//             values are hand-computed from the stripe geometry
//             (first stripe at 30.48e9 nm, pitch 30.48e9 nm, width
//             101.6e6 nm, offsets F=2.54e9 nm, M=1.27e9 nm, R=0).
//  Options  : REFLECT_STRIPE_COUNT_EN enables the stripeCount checks
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reflect_sensors;

   logic        clk;
   logic        rst_n;
   logic [63:0] position;
   logic        reflectF;
   logic        reflectM;
   logic        reflectR;
`ifdef REFLECT_STRIPE_COUNT_EN
   logic [7:0]  stripeCount;
`endif

   int n_total;
   int n_bad;

   reflect_sensors dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .position    (position),
      .reflectF    (reflectF),
      .reflectM    (reflectM),
      .reflectR    (reflectR)
`ifdef REFLECT_STRIPE_COUNT_EN
      ,
      .stripeCount (stripeCount)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Apply a position at the falling edge. Wait through the two capture
   // edges and return at the next falling edge. The outputs then reflect p.
   task automatic step_pos(input logic [63:0] p);
      position = p;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      logic [63:0] p;
      logic [63:0] f_rise, f_fall, m_rise, m_fall, r_rise, r_fall;
      int          f_cnt, m_cnt, r_cnt;
      logic        pf, pm, pr;

      n_total = 0;
      n_bad   = 0;

      // ---------------- reset ----------------
      rst_n    = 1'b0;
      position = 64'd30480000000;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_F", {63'd0, reflectF}, 64'd0);
      check("rst_M", {63'd0, reflectM}, 64'd0);
      check("rst_R", {63'd0, reflectR}, 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("rel_R", {63'd0, reflectR}, 64'd1);
      check("rel_F", {63'd0, reflectF}, 64'd0);
      check("rel_M", {63'd0, reflectM}, 64'd0);
      @(negedge clk);

      // ---------------- sweep ----------------
      f_rise = '0; f_fall = '0; m_rise = '0; m_fall = '0; r_rise = '0; r_fall = '0;
      f_cnt = 0; m_cnt = 0; r_cnt = 0;
      pf = 1'b0; pm = 1'b0; pr = 1'b0;
      p = 64'd15240000000;
      while (p <= 64'd30600000000) begin
         step_pos(p);
         if (reflectF && !pf) f_rise = p;
         if (!reflectF && pf) f_fall = p;
         if (reflectM && !pm) m_rise = p;
         if (!reflectM && pm) m_fall = p;
         if (reflectR && !pr) r_rise = p;
         if (!reflectR && pr) r_fall = p;
         if (reflectF) f_cnt++;
         if (reflectM) m_cnt++;
         if (reflectR) r_cnt++;
         pf = reflectF; pm = reflectM; pr = reflectR;
         p = p + 64'd2540000;
      end
      check("sweep_F_rise", f_rise, 64'd27940000000);
      check("sweep_F_fall", f_fall, 64'd28041600000);
      check("sweep_F_cnt", 64'(f_cnt), 64'd40);
      check("sweep_M_rise", m_rise, 64'd29210000000);
      check("sweep_M_fall", m_fall, 64'd29311600000);
      check("sweep_M_cnt", 64'(m_cnt), 64'd40);
      check("sweep_R_rise", r_rise, 64'd30480000000);
      check("sweep_R_fall", r_fall, 64'd30581600000);
      check("sweep_R_cnt", 64'(r_cnt), 64'd40);

      // ---------------- edges ----------------
      step_pos(64'd30480000000); check("edge_lead", {63'd0, reflectR}, 64'd1);
      step_pos(64'd30581599999); check("edge_last", {63'd0, reflectR}, 64'd1);
      step_pos(64'd30581600000); check("edge_trail", {63'd0, reflectR}, 64'd0);
      step_pos(64'd30479999999); check("edge_before", {63'd0, reflectR}, 64'd0);

      // ---------------- range ends ----------------
      step_pos(64'd1249680000000); check("last_stripe_R", {63'd0, reflectR}, 64'd1);
      step_pos(64'd1280160000000); check("past_last_R", {63'd0, reflectR}, 64'd0);
      step_pos(64'hFFFF_FFFF_FFFF_FFFF);
      check("ovf_F", {63'd0, reflectF}, 64'd0);
      check("ovf_R", {63'd0, reflectR}, 64'd0);
      step_pos(64'd0);
      check("zero_F", {63'd0, reflectF}, 64'd0);
      check("zero_M", {63'd0, reflectM}, 64'd0);
      check("zero_R", {63'd0, reflectR}, 64'd0);

      // Two sensors over stripes simultaneously: F on stripe 1 and R on stripe 2.
      // These need offsets F-R = pitch, which do not fit here. Instead, check M
      // alone at the M leading edge of stripe 1.
      step_pos(64'd59690000000);
      check("m_stripe1", {63'd0, reflectM}, 64'd1);
      check("m_stripe1_R", {63'd0, reflectR}, 64'd0);

      // ---------------- asynchronous reset ----------------
      step_pos(64'd30480000000);
      check("pre_async_R", {63'd0, reflectR}, 64'd1);
      rst_n = 1'b0;
      #1;
      check("async_rst_R", {63'd0, reflectR}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

`ifdef REFLECT_STRIPE_COUNT_EN
      begin
         logic [7:0] c0;
         rst_n = 1'b0;
         #1;
         check("cnt_rst", {56'd0, stripeCount}, 64'd0);
         @(negedge clk);
         rst_n = 1'b1;
         p = 64'd15240000000;
         while (p <= 64'd90000000000) begin
            step_pos(p);
            p = p + 64'd25400000;
         end
         check("cnt_three", {56'd0, stripeCount}, 64'd3);
         c0 = stripeCount;
         for (int i = 0; i < 5; i++) begin
            step_pos(64'd88900000000);
            check("cnt_toggle", {56'd0, stripeCount}, 64'(c0) + 64'(i) + 64'd1);
            step_pos(64'd88899999999);
         end
         check("cnt_plus5", {56'd0, stripeCount}, 64'(c0) + 64'd5);
         for (int i = 0; i < 260; i++) begin
            step_pos(64'd88900000000);
            step_pos(64'd88899999999);
         end
         check("cnt_sat", {56'd0, stripeCount}, 64'd255);
      end
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
